// File: rtl/ln_series_pkg.sv
// ----------------------------------------------------------------------------
// ln_series_pkg
// Shared constants for the resource-shared ln(1+x) series core: fp32 constants,
// arithmetic unit latencies, the Taylor coefficient table and the FSM states.
// ----------------------------------------------------------------------------
package ln_series_pkg;

   localparam logic [31:0] FP_ONE  = 32'h3f800000;
   localparam logic [31:0] FP_QNAN = 32'h7fc00000;

   // Cycles from operand presentation to the capture edge, inclusive.
   localparam int MUL_LAT = 5;
   localparam int ADD_LAT = 7;

   // c[k] = (-1)^(k+1) / k in fp32, k = 1..9
   localparam logic [31:0] COEF_TABLE [1:9] = '{
      32'h3f800000, 32'hbf000000, 32'h3eaaaaab,
      32'hbe800000, 32'h3e4ccccd, 32'hbe2aaaab,
      32'h3e124925, 32'hbe000000, 32'h3de38e39
   };

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_MUL      = 3'd1,
      S_ADD      = 3'd2,
      S_FINAL    = 3'd3,
      S_DONE_ERR = 3'd4
   } state_t;

endpackage

// File: rtl/add7.sv
// ----------------------------------------------------------------------------
// add7
// Free-running fp32 adder, no reset. Operands held for one cycle appear on
// o_s six edges later, so the owner captures on the seventh edge.
// Denormal inputs flush to zero; overflow saturates to infinity; RNE rounding.
//   clk : clock
//   i_a : fp32 operand
//   i_b : fp32 operand
//   o_s : fp32 sum
// ----------------------------------------------------------------------------
module add7
   import ln_series_pkg::*;
(
   input  logic        clk,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_s
);

   localparam int STAGES = ADD_LAT - 1;

   logic        w_swap, w_guard, w_sticky, w_rnd;
   logic [31:0] w_big, w_sml, w_res;
   logic [7:0]  w_d;
   logic [27:0] w_mb, w_ms, w_al, w_sum;
   logic [26:0] w_norm;
   logic [4:0]  w_lead, w_sh;
   logic [24:0] w_mant;
   logic [9:0]  w_exp;
   logic [31:0] r_pipe [STAGES];

   always_comb begin
      // Order by magnitude so the subtraction below never goes negative.
      w_swap = i_b[30:0] > i_a[30:0];
      w_big  = w_swap ? i_b : i_a;
      w_sml  = w_swap ? i_a : i_b;
      // Hidden one at bit 26, three guard bits below, carry room at bit 27.
      w_mb   = (w_big[30:23] == 8'd0) ? 28'd0 : {2'b01, w_big[22:0], 3'b000};
      w_ms   = (w_sml[30:23] == 8'd0) ? 28'd0 : {2'b01, w_sml[22:0], 3'b000};
      w_d    = w_big[30:23] - w_sml[30:23];
      w_al   = (w_d > 8'd27) ? 28'd0 : (w_ms >> w_d);
      w_sum  = (w_big[31] == w_sml[31]) ? (w_mb + w_al) : (w_mb - w_al);

      w_lead = 5'd0;
      for (int i = 0; i < 28; i++) begin
         if (w_sum[i]) w_lead = 5'(i);
      end

      w_sh = 5'd0;
      if (w_lead == 5'd27) begin
         w_norm   = w_sum[27:1];
         w_exp    = {2'b00, w_big[30:23]} + 10'd1;
         w_sticky = (|w_norm[1:0]) | w_sum[0];
      end else begin
         w_sh     = 5'd26 - w_lead;
         w_norm   = w_sum[26:0] << w_sh;
         w_exp    = {2'b00, w_big[30:23]} - {5'd0, w_sh};
         w_sticky = |w_norm[1:0];
      end

      w_guard = w_norm[2];
      w_rnd   = w_guard & (w_sticky | w_norm[3]);
      w_mant  = {1'b0, w_norm[26:3]} + {24'd0, w_rnd};
      w_exp   = w_exp + {9'd0, w_mant[24]};

      w_res = 32'd0;
      if ((w_sum != 28'd0) && ($signed(w_exp) > 10'sd0)) begin
         if ($signed(w_exp) >= 10'sd255) w_res = {w_big[31], 8'hff, 23'd0};
         else w_res = {w_big[31], w_exp[7:0], (w_mant[24] ? w_mant[23:1] : w_mant[22:0])};
      end
   end

   always_ff @(posedge clk) begin
      r_pipe[0] <= w_res;
      for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
   end

   assign o_s = r_pipe[STAGES-1];

endmodule

// File: rtl/ln_coef_rom.sv
// ----------------------------------------------------------------------------
// ln_coef_rom
// Combinational lookup of the series coefficient c[k].
//   i_k : term index, 1..9 are valid
//   o_c : fp32 coefficient, zero for any other index
// ----------------------------------------------------------------------------
module ln_coef_rom
   import ln_series_pkg::*;
(
   input  logic [3:0]  i_k,
   output logic [31:0] o_c
);

   always_comb begin
      o_c = '0;
      for (int i = 1; i <= 9; i++) begin
         if (i_k == 4'(i)) o_c = COEF_TABLE[i];
      end
   end

endmodule

// File: rtl/mult5.sv
// ----------------------------------------------------------------------------
// mult5
// Free-running fp32 multiplier, no reset. Operands held for one cycle appear
// on o_p four edges later, so the owner captures on the fifth edge.
// Denormal inputs flush to zero; overflow saturates to infinity; RNE rounding.
//   clk : clock
//   i_a : fp32 operand
//   i_b : fp32 operand
//   o_p : fp32 product
// ----------------------------------------------------------------------------
module mult5
   import ln_series_pkg::*;
(
   input  logic        clk,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_p
);

   localparam int STAGES = MUL_LAT - 1;

   logic [47:0] w_ma, w_mb, w_p;
   logic        w_norm, w_guard, w_sticky, w_lsb, w_rnd, w_sign;
   logic [24:0] w_mant;
   logic [9:0]  w_exp;
   logic [31:0] w_res;
   logic [31:0] r_pipe [STAGES];

   always_comb begin
      w_ma     = {24'd0, 1'b1, i_a[22:0]};
      w_mb     = {24'd0, 1'b1, i_b[22:0]};
      w_p      = w_ma * w_mb;
      w_norm   = w_p[47];
      w_guard  = w_norm ? w_p[23] : w_p[22];
      w_sticky = w_norm ? (|w_p[22:0]) : (|w_p[21:0]);
      w_lsb    = w_norm ? w_p[24] : w_p[23];
      w_rnd    = w_guard & (w_sticky | w_lsb);
      w_mant   = {1'b0, (w_norm ? w_p[47:24] : w_p[46:23])} + {24'd0, w_rnd};
      w_exp    = {2'b00, i_a[30:23]} + {2'b00, i_b[30:23]} - 10'd127
               + {9'd0, w_norm} + {9'd0, w_mant[24]};
      w_sign   = i_a[31] ^ i_b[31];
      w_res    = {w_sign, 31'd0};
      if ((i_a[30:23] != 8'd0) && (i_b[30:23] != 8'd0) && ($signed(w_exp) > 10'sd0)) begin
         if ($signed(w_exp) >= 10'sd255) w_res = {w_sign, 8'hff, 23'd0};
         else w_res = {w_sign, w_exp[7:0], (w_mant[24] ? w_mant[23:1] : w_mant[22:0])};
      end
   end

   always_ff @(posedge clk) begin
      r_pipe[0] <= w_res;
      for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
   end

   assign o_p = r_pipe[STAGES-1];

endmodule

// File: rtl/ln_series_core.sv
// ----------------------------------------------------------------------------
// ln_series_core
// ln(1+x) by an N_TERMS Taylor series evaluated with Horner's rule on one
// shared multiplier and one shared adder.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   x     : fp32 operand, sampled when start is accepted
//   start : request, accepted only while busy is low
//   busy  : high from the cycle after acceptance until the done cycle
//   ln    : fp32 result, held until the next done
//   done  : one-cycle pulse when ln/error update
//   error : |x| > 1.0 for the completed request, held with ln
// Handshake: start is taken on any rising edge where busy=0 and start=1;
// starts seen while busy=1 are dropped. done rises with busy already low, so
// a start in the done cycle is accepted without a bubble.
// ----------------------------------------------------------------------------
module ln_series_core
   import ln_series_pkg::*;
#(
   parameter int N_TERMS = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] x,
   input  logic        start,
   output logic        busy,
   output logic [31:0] ln,
   output logic        done,
   output logic        error
);

   generate
      if ((N_TERMS < 2) || (N_TERMS > 9)) begin : g_bad_terms
         $error("ln_series_core: N_TERMS must be in 2..9");
      end
   endgenerate

   localparam logic [3:0] K_TOP    = 4'(N_TERMS);
   localparam logic [3:0] K_FIRST  = 4'(N_TERMS - 1);
   localparam logic [2:0] MUL_LAST = 3'(MUL_LAT - 1);
   localparam logic [2:0] ADD_LAST = 3'(ADD_LAT - 1);

   state_t      r_state, w_next;
   logic [2:0]  r_cnt;
   logic [3:0]  r_k;
   logic [31:0] r_x_q, r_acc, r_prod, r_ln;
   logic        r_done, r_error;

   logic        w_busy, w_accept, w_x_err, w_mul_cap, w_add_cap;
   logic [3:0]  w_rom_k;
   logic [31:0] w_coef, w_mul_p, w_add_s;

   // The ROM serves c[N] at acceptance and c[k] while adding.
   ln_coef_rom u_rom (.i_k(w_rom_k), .o_c(w_coef));
   mult5       u_mul (.clk(clk), .i_a(r_x_q), .i_b(r_acc),  .o_p(w_mul_p));
   add7        u_add (.clk(clk), .i_a(w_coef), .i_b(r_prod), .o_s(w_add_s));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (start) w_next = w_x_err ? S_DONE_ERR : S_MUL;
         S_MUL:      if (w_mul_cap) w_next = (r_k != 4'd0) ? S_ADD : S_FINAL;
         S_ADD:      if (w_add_cap) w_next = S_MUL;
         S_FINAL:    w_next = S_IDLE;
         S_DONE_ERR: w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      w_busy    = (r_state != S_IDLE);
      w_accept  = (r_state == S_IDLE) && start;
      w_x_err   = {1'b0, x[30:0]} > FP_ONE;
      w_mul_cap = (r_state == S_MUL) && (r_cnt == MUL_LAST);
      w_add_cap = (r_state == S_ADD) && (r_cnt == ADD_LAST);
      w_rom_k   = (r_state == S_IDLE) ? K_TOP : r_k;
   end

   // Datapath and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_k     <= '0;
         r_x_q   <= '0;
         r_acc   <= '0;
         r_prod  <= '0;
         r_ln    <= '0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // Cycle counter restarts on every phase change.
         if (((r_state == S_MUL) || (r_state == S_ADD)) && !w_mul_cap && !w_add_cap)
            r_cnt <= r_cnt + 3'd1;
         else
            r_cnt <= '0;

         if (w_accept) begin
            r_x_q <= x;
            r_acc <= w_coef;
            r_k   <= K_FIRST;
         end
         if (w_mul_cap) r_prod <= w_mul_p;
         if (w_add_cap) begin
            r_acc <= w_add_s;
            r_k   <= r_k - 4'd1;
         end

         if (r_state == S_FINAL) begin
            r_ln    <= r_prod;
            r_error <= 1'b0;
            r_done  <= 1'b1;
         end else if (r_state == S_DONE_ERR) begin
            r_ln    <= FP_QNAN;
            r_error <= 1'b1;
            r_done  <= 1'b1;
         end
      end
   end

   assign busy  = w_busy;
   assign ln    = r_ln;
   assign done  = r_done;
   assign error = r_error;

endmodule

// File: tb/tb_ln_series_core.sv
module tb_ln_series_core;

   logic        clk;
   logic        rst_n;
   logic [31:0] x5, x2;
   logic        start5, start2;
   logic        busy5, busy2;
   logic [31:0] ln5, ln2;
   logic        done5, done2;
   logic        error5, error2;

   int n_vec = 0;
   int n_bad = 0;

   // Expected results, hand-derived: ln(1+x) series sums rounded to fp32.
   localparam logic [31:0] X_HALF   = 32'h3f000000;
   localparam logic [31:0] EXP_HALF = 32'h3ed08889; // 0.4072917, 5 terms
   localparam logic [31:0] EXP_HALF2= 32'h3ec00000; // 0.375, 2 terms
   localparam logic [31:0] EXP_NEG1 = 32'hc0122222; // -2.283333
   localparam logic [31:0] EXP_ONE  = 32'h3f488889; // 0.7833333
   localparam int          LAT5     = 54;
   localparam int          LAT2     = 18;

   ln_series_core #(.N_TERMS(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .x(x5), .start(start5),
      .busy(busy5), .ln(ln5), .done(done5), .error(error5)
   );

   ln_series_core #(.N_TERMS(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .x(x2), .start(start2),
      .busy(busy2), .ln(ln2), .done(done2), .error(error2)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Within 2 ulp, same sign.
   function automatic bit near(input logic [31:0] a, input logic [31:0] e);
      int d;
      if (a[31] !== e[31]) return 1'b0;
      d = int'(a[30:0]) - int'(e[30:0]);
      return (d >= -2) && (d <= 2);
   endfunction

   // ---------------- drivers ----------------
   task automatic issue5(input logic [31:0] xv);
      x5 = xv;
      start5 = 1'b1;
      @(posedge clk); #1;
      start5 = 1'b0;
   endtask

   task automatic wait_done5(input int budget, output int lat);
      lat = -1;
      for (int c = 1; c <= budget; c++) begin
         @(posedge clk); #1;
         if (done5) begin
            lat = c;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      n_vec++; if (busy5 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy5); end
      n_vec++; if (done5 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done5); end
      n_vec++; if (ln5 !== 32'h0) begin n_bad++; $display("FAIL reset_ln: got %h want 00000000", ln5); end
      n_vec++; if (error5 !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", error5); end
      n_vec++; if (busy2 !== 1'b0 || ln2 !== 32'h0) begin n_bad++; $display("FAIL reset_dut2: got busy %b ln %h want 0/0", busy2, ln2); end
   endtask

   task automatic test_zero;
      int lat;
      issue5(32'h00000000);
      wait_done5(100, lat);
      n_vec++; if (lat !== LAT5) begin n_bad++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT5); end
      n_vec++; if (ln5 !== 32'h0) begin n_bad++; $display("FAIL zero_ln: got %h want 00000000", ln5); end
      n_vec++; if (error5 !== 1'b0) begin n_bad++; $display("FAIL zero_error: got %b want 0", error5); end
      n_vec++; if (busy5 !== 1'b0) begin n_bad++; $display("FAIL zero_busy_in_done: got %b want 0", busy5); end
   endtask

   task automatic test_valid;
      logic [31:0] xs [3] = '{X_HALF, 32'hbf800000, 32'h3f800000};
      logic [31:0] es [3] = '{EXP_HALF, EXP_NEG1, EXP_ONE};
      int lat;
      for (int i = 0; i < 3; i++) begin
         issue5(xs[i]);
         wait_done5(100, lat);
         n_vec++; if (lat !== LAT5) begin n_bad++; $display("FAIL valid_latency[%0d]: got %0d want %0d", i, lat, LAT5); end
         n_vec++; if (!near(ln5, es[i])) begin n_bad++; $display("FAIL valid_ln[%0d]: got %h want %h +-2ulp", i, ln5, es[i]); end
         n_vec++; if (error5 !== 1'b0) begin n_bad++; $display("FAIL valid_error[%0d]: got %b want 0", i, error5); end
      end
   endtask

   task automatic test_error;
      logic [31:0] xs [3] = '{32'h3fc00000, 32'hc0000000, 32'h3f800001};
      int lat;
      for (int i = 0; i < 3; i++) begin
         issue5(xs[i]);
         wait_done5(10, lat);
         n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL err_latency[%0d]: got %0d want 1", i, lat); end
         n_vec++; if (ln5 !== 32'h7fc00000) begin n_bad++; $display("FAIL err_ln[%0d]: got %h want 7fc00000", i, ln5); end
         n_vec++; if (error5 !== 1'b1) begin n_bad++; $display("FAIL err_flag[%0d]: got %b want 1", i, error5); end
      end
   endtask

   task automatic test_n2;
      int lat = -1;
      x2 = X_HALF;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (done2) begin
            lat = c;
            break;
         end
      end
      n_vec++; if (lat !== LAT2) begin n_bad++; $display("FAIL n2_latency: got %0d want %0d", lat, LAT2); end
      n_vec++; if (!near(ln2, EXP_HALF2)) begin n_bad++; $display("FAIL n2_ln: got %h want %h +-2ulp", ln2, EXP_HALF2); end
      n_vec++; if (error2 !== 1'b0) begin n_bad++; $display("FAIL n2_error: got %b want 0", error2); end
   endtask

   task automatic test_busy_ignore;
      logic [31:0] junk [4] = '{32'h3fc00000, 32'hbf800000, 32'h00000000, 32'h3f800000};
      int n_done = 0;
      int lat = -1;
      logic [31:0] got_ln = '0;
      logic got_err = 1'b1;
      issue5(X_HALF);
      for (int c = 1; c <= 70; c++) begin
         start5 = (c < LAT5);
         x5 = junk[c % 4];
         @(posedge clk); #1;
         if (done5) begin
            n_done++;
            lat = c;
            got_ln = ln5;
            got_err = error5;
         end
      end
      start5 = 1'b0;
      n_vec++; if (n_done !== 1) begin n_bad++; $display("FAIL busy_done_count: got %0d want 1", n_done); end
      n_vec++; if (lat !== LAT5) begin n_bad++; $display("FAIL busy_latency: got %0d want %0d", lat, LAT5); end
      n_vec++; if (!near(got_ln, EXP_HALF)) begin n_bad++; $display("FAIL busy_ln: got %h want %h +-2ulp", got_ln, EXP_HALF); end
      n_vec++; if (got_err !== 1'b0) begin n_bad++; $display("FAIL busy_error: got %b want 0", got_err); end
   endtask

   task automatic test_back_to_back;
      int lat1, lat2;
      issue5(X_HALF);
      wait_done5(100, lat1);
      n_vec++; if (lat1 !== LAT5) begin n_bad++; $display("FAIL b2b_lat1: got %0d want %0d", lat1, LAT5); end
      n_vec++; if (!near(ln5, EXP_HALF)) begin n_bad++; $display("FAIL b2b_ln1: got %h want %h +-2ulp", ln5, EXP_HALF); end
      // Start in the done cycle itself.
      issue5(32'hbf800000);
      n_vec++; if (busy5 !== 1'b1 || done5 !== 1'b0) begin n_bad++; $display("FAIL b2b_accept: got busy %b done %b want 1/0", busy5, done5); end
      wait_done5(100, lat2);
      n_vec++; if (lat2 + 1 !== LAT5 + 1) begin n_bad++; $display("FAIL b2b_gap: got %0d want %0d", lat2 + 1, LAT5 + 1); end
      n_vec++; if (!near(ln5, EXP_NEG1)) begin n_bad++; $display("FAIL b2b_ln2: got %h want %h +-2ulp", ln5, EXP_NEG1); end
      n_vec++; if (error5 !== 1'b0) begin n_bad++; $display("FAIL b2b_error2: got %b want 0", error5); end
   endtask

   task automatic test_reset_midop;
      int n_done = 0;
      int lat;
      issue5(X_HALF);
      repeat (19) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_vec++; if (busy5 !== 1'b0 || done5 !== 1'b0) begin n_bad++; $display("FAIL rst_async_ctl: got busy %b done %b want 0/0", busy5, done5); end
      n_vec++; if (ln5 !== 32'h0 || error5 !== 1'b0) begin n_bad++; $display("FAIL rst_async_out: got ln %h err %b want 0/0", ln5, error5); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 70; c++) begin
         @(posedge clk); #1;
         if (done5) n_done++;
      end
      n_vec++; if (n_done !== 0) begin n_bad++; $display("FAIL rst_no_done: got %0d want 0", n_done); end
      issue5(X_HALF);
      wait_done5(100, lat);
      n_vec++; if (lat !== LAT5) begin n_bad++; $display("FAIL rst_after_latency: got %0d want %0d", lat, LAT5); end
      n_vec++; if (!near(ln5, EXP_HALF)) begin n_bad++; $display("FAIL rst_after_ln: got %h want %h +-2ulp", ln5, EXP_HALF); end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      rst_n = 1'b0;
      x5 = '0; x2 = '0;
      start5 = 1'b0; start2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      test_reset;
      test_zero;
      test_valid;
      test_error;
      test_n2;
      test_busy_ignore;
      test_back_to_back;
      test_reset_midop;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
